// File: rtl/regwb_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
// Holds the queued-entry layout and the wrap-aware stamp age comparison.
package regwb_pkg;

  localparam int REG_AW = 4;
  localparam int REG_DW = 16;
  localparam int SW     = 3;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [REG_DW-1:0] data;
    logic [SW-1:0]     stamp;
  } wb_entry_t;

  // a is older than b when b is ahead of a by less than half the stamp space
  function automatic logic older(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] diff;
    diff = b - a;
    return (diff != '0) && (diff < SW'(1 << (SW - 1)));
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small shift-style write-request FIFO: pop is applied before push in the same cycle.
// Exposes every entry's valid/dst so the top can build the pending-register map.
module wb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  wb_entry_t                      push_ent_i,
  input  logic                           pop_i,
  output wb_entry_t                      head_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [DEPTH-1:0]               ent_vld_o,
  output logic [DEPTH-1:0][REG_AW-1:0]   ent_dst_o
);

  wb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic      [DEPTH-1:0] vld_q, vld_d;

  always_comb begin
    logic placed;
    vld_d  = vld_q;
    ent_d  = ent_q;
    placed = 1'b0;
    if (pop_i) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        vld_d[i] = vld_q[i+1];
        ent_d[i] = ent_q[i+1];
      end
      vld_d[DEPTH-1] = 1'b0;
    end
    // new entry lands in the first free slot after the pop has compacted the queue
    if (push_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!vld_d[i] && !placed) begin
          vld_d[i] = 1'b1;
          ent_d[i] = push_ent_i;
          placed   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_dst_o[i] = ent_q[i].dst;
  end

  assign head_o    = ent_q[0];
  assign empty_o   = ~vld_q[0];
  assign full_o    = vld_q[DEPTH-1];
  assign ent_vld_o = vld_q;

endmodule

// File: rtl/regwb_arbiter.sv
// Write-back arbiter: two queued producers share the register file's single write port.
// Round-robin between heads, but same-destination heads always issue oldest stamp first.
module regwb_arbiter
  import regwb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SW    = regwb_pkg::SW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v0,
  input  logic [REG_AW-1:0] dst0,
  input  logic [REG_DW-1:0] data0,
  output logic              rdy0,
  input  logic              v1,
  input  logic [REG_AW-1:0] dst1,
  input  logic [REG_DW-1:0] data1,
  output logic              rdy1,
  output logic              regwrite,
  output logic [REG_AW-1:0] regdst,
  output logic [REG_DW-1:0] writedata,
  output logic [15:0]       busy
);

  wb_entry_t                        in0, in1, head0, head1;
  logic                             full0, full1, empty0, empty1;
  logic [DEPTH-1:0]                 evld0, evld1;
  logic [DEPTH-1:0][REG_AW-1:0]     edst0, edst1;
  logic                             acc0, acc1, pop0, pop1;
  logic                             gnt_vld, gnt_sel;
  logic [SW-1:0]                    stamp_q, stamp_d;
  logic                             last_grant_q;
  logic                             regwrite_q;
  logic [REG_AW-1:0]                regdst_q;
  logic [REG_DW-1:0]                writedata_q;
  logic [15:0]                      busy_c;

  // Ready depends only on registered fullness, never on v or this cycle's pop
  assign rdy0 = ~full0 & ~rst;
  assign rdy1 = ~full1 & ~rst;
  assign acc0 = v0 & rdy0;
  assign acc1 = v1 & rdy1;

  assign in0     = '{dst: dst0, data: data0, stamp: stamp_q};
  assign in1     = '{dst: dst1, data: data1, stamp: stamp_q + SW'(acc0)};
  assign stamp_d = stamp_q + SW'(acc0) + SW'(acc1);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .push_i(acc0), .push_ent_i(in0), .pop_i(pop0),
    .head_o(head0), .full_o(full0), .empty_o(empty0),
    .ent_vld_o(evld0), .ent_dst_o(edst0)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .push_i(acc1), .push_ent_i(in1), .pop_i(pop1),
    .head_o(head1), .full_o(full1), .empty_o(empty1),
    .ent_vld_o(evld1), .ent_dst_o(edst1)
  );

  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = 1'b0;
    if (!empty0 && !empty1) begin
      gnt_vld = 1'b1;
      if (head0.dst == head1.dst) gnt_sel = ~older(head0.stamp, head1.stamp);
      else                        gnt_sel = ~last_grant_q;
    end else if (!empty0) begin
      gnt_vld = 1'b1;
    end else if (!empty1) begin
      gnt_vld = 1'b1;
      gnt_sel = 1'b1;
    end
  end

  assign pop0 = gnt_vld & ~gnt_sel;
  assign pop1 = gnt_vld &  gnt_sel;

  // Output stage: one registered write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      stamp_q      <= '0;
      last_grant_q <= 1'b1;
      regwrite_q   <= 1'b0;
      regdst_q     <= '0;
      writedata_q  <= '0;
    end else begin
      stamp_q    <= stamp_d;
      regwrite_q <= gnt_vld;
      if (gnt_vld) begin
        last_grant_q <= gnt_sel;
        regdst_q     <= gnt_sel ? head1.dst  : head0.dst;
        writedata_q  <= gnt_sel ? head1.data : head0.data;
      end
    end
  end

  always_comb begin
    busy_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (evld0[i]) busy_c[edst0[i]] = 1'b1;
      if (evld1[i]) busy_c[edst1[i]] = 1'b1;
    end
    if (regwrite_q) busy_c[regdst_q] = 1'b1;
  end

  assign regwrite  = regwrite_q;
  assign regdst    = regdst_q;
  assign writedata = writedata_q;
  assign busy      = busy_c;

endmodule

// File: tb/tb_regwb_arbiter.sv
// Randomized and directed bench for regwb_arbiter with a queue-based reference model
// and a scoreboard monitor that checks every issued write, ready and the pending map.
module tb_regwb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [3:0]  dst0 = '0, dst1 = '0;
  logic [15:0] data0 = '0, data1 = '0;
  logic        rdy0, rdy1, regwrite;
  logic [3:0]  regdst;
  logic [15:0] writedata, busy;

  always #5 clk = ~clk;

  regwb_arbiter dut (
    .clk(clk), .rst(rst),
    .v0(v0), .dst0(dst0), .data0(data0), .rdy0(rdy0),
    .v1(v1), .dst1(dst1), .data1(data1), .rdy1(rdy1),
    .regwrite(regwrite), .regdst(regdst), .writedata(writedata), .busy(busy)
  );

  typedef struct { int dst; int data; int stamp; } ment_t;
  typedef struct { int dst; int data; } exp_t;

  ment_t mq0[$], mq1[$];
  exp_t  exp_q[$];
  int    m_stamp = 0, m_last = 1, m_out_vld = 0, m_out_dst = 0;
  int    n_chk = 0, n_fail = 0;

  function automatic bit m_older(int a, int b);
    int d;
    d = (b - a + 8) % 8;
    return (d >= 1) && (d <= 3);
  endfunction

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-requester queues, arbitration rules applied to the queue heads
  always @(posedge clk) begin : model
    bit    a0, a1;
    int    g;
    ment_t e;
    if (rst) begin
      mq0.delete(); mq1.delete(); exp_q.delete();
      m_stamp = 0; m_last = 1; m_out_vld = 0;
    end else begin
      a0 = v0 && (mq0.size() < 2);
      a1 = v1 && (mq1.size() < 2);
      g = -1;
      if (mq0.size() > 0 && mq1.size() > 0) begin
        if (mq0[0].dst == mq1[0].dst) g = m_older(mq0[0].stamp, mq1[0].stamp) ? 0 : 1;
        else                          g = 1 - m_last;
      end else if (mq0.size() > 0) g = 0;
      else if (mq1.size() > 0)     g = 1;
      m_out_vld = (g >= 0);
      if (g == 0) e = mq0.pop_front();
      if (g == 1) e = mq1.pop_front();
      if (g >= 0) begin
        exp_q.push_back('{e.dst, e.data});
        m_out_dst = e.dst;
        m_last = g;
      end
      if (a0) mq0.push_back('{int'(dst0), int'(data0), m_stamp});
      if (a1) mq1.push_back('{int'(dst1), int'(data1), (m_stamp + int'(a0)) % 8});
      m_stamp = (m_stamp + int'(a0) + int'(a1)) % 8;
    end
  end

  // Monitor: compares DUT against the model just after every active edge
  initial begin : monitor
    logic [15:0] eb;
    exp_t        x;
    forever begin
      @(posedge clk); #1;
      eb = '0;
      foreach (mq0[i]) eb[mq0[i].dst] = 1'b1;
      foreach (mq1[i]) eb[mq1[i].dst] = 1'b1;
      if (m_out_vld != 0) eb[m_out_dst] = 1'b1;
      check("rdy0", int'(rdy0), int'((mq0.size() < 2) && !rst));
      check("rdy1", int'(rdy1), int'((mq1.size() < 2) && !rst));
      check("busy", int'(busy), int'(eb));
      check("regwrite", int'(regwrite), m_out_vld);
      if (regwrite) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          x = exp_q.pop_front();
          check("regdst", int'(regdst), x.dst);
          check("writedata", int'(writedata), x.data);
        end
      end
    end
  end

  task automatic step(input bit a, input int d0, input int x0,
                      input bit b, input int d1, input int x1);
    v0 = a; dst0 = 4'(d0); data0 = 16'(x0);
    v1 = b; dst1 = 4'(d1); data1 = 16'(x1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stim
    rst = 1'b1;
    repeat (3) step(1, 2, 16'h1111, 1, 3, 16'h2222);
    rst = 1'b0;
    idle(1);

    step(1, 5, 16'h1234, 0, 0, 0);
    idle(4);

    for (int i = 0; i < 8; i++) step(1, i, 16'h0100 + i, 1, 8 + i, 16'h0200 + i);
    idle(6);

    step(1, 7, 16'h0777, 1, 8, 16'h0888);
    step(0, 0, 0, 1, 3, 16'hAAAA);
    step(1, 3, 16'hBBBB, 0, 0, 0);
    idle(6);

    for (int i = 0; i < 6; i++) step(1, i, 16'h0300 + i, 1, 8 + (i % 4), 16'h0400 + i);
    idle(6);

    step(1, 1, 16'h0501, 1, 2, 16'h0502);
    step(1, 9, 16'h0509, 0, 0, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(4);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(99) == 0);
      step($urandom_range(3) != 0, $urandom_range(3), $urandom_range(16'hFFFF),
           $urandom_range(3) != 0, $urandom_range(3), $urandom_range(16'hFFFF));
    end
    rst = 1'b0;
    idle(10);

    check("drain_expected", exp_q.size(), 0);
    check("drain_queues", mq0.size() + mq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
